// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the rf_port_arbiter register-file sequencer.
// The command struct is sized for the 4x32 register file the arbiter fronts.
package rf_arb_pkg;

    localparam int RF_ARB_NREQ   = 2;
    localparam int RF_ARB_DATA_W = 32;
    localparam int RF_ARB_ADDR_W = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } rf_arb_state_e;

    typedef struct packed {
        logic                     we;
        logic [RF_ARB_ADDR_W-1:0] addr;
        logic [RF_ARB_DATA_W-1:0] wdata;
    } rf_cmd_t;

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational 2-way picker producing a one-hot winner.
// Ties go to the requester that did not win last, or always to r0 when RF_ARB_FIXED_PRIO_EN is defined.
module rf_rr_pick
    import rf_arb_pkg::*;
(
    input  logic [RF_ARB_NREQ-1:0] req,
    input  logic                   last_gnt,
    output logic [RF_ARB_NREQ-1:0] win
);

`ifdef RF_ARB_FIXED_PRIO_EN
    logic unused_last_gnt_s;
    assign unused_last_gnt_s = last_gnt;
`endif

    // Winner selection
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
`ifdef RF_ARB_FIXED_PRIO_EN
            2'b11:   win = 2'b01;
`else
            2'b11:   win = last_gnt ? 2'b01 : 2'b10;
`endif
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port register file; one access per two cycles.
// Tie-breaking is round-robin unless RF_ARB_FIXED_PRIO_EN is defined (r0 then always wins ties).
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = RF_ARB_DATA_W,
    parameter int ADDR_W = RF_ARB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              rf_wen,
    output logic              rf_ren,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);

    rf_arb_state_e          state_q, state_d;
    logic                   last_gnt_q, last_gnt_d;
    rf_cmd_t                cmd_q, cmd_d;
    logic [RF_ARB_NREQ-1:0] gnt_q, gnt_d;
    logic [RF_ARB_NREQ-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   busy_q, busy_d;
    logic                   rf_wen_q, rf_wen_d;
    logic                   rf_ren_q, rf_ren_d;
    logic [RF_ARB_NREQ-1:0] win_s;

    rf_rr_pick u_pick (
        .req      ({r1_req, r0_req}),
        .last_gnt (last_gnt_q),
        .win      (win_s)
    );

    // Next-state and next-output computation
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cmd_d      = cmd_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        rd_data_d  = rd_data_q;
        busy_d     = 1'b0;
        rf_wen_d   = 1'b0;
        rf_ren_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_s != 2'b00) begin
                    state_d    = ACCESS;
                    gnt_d      = win_s;
                    last_gnt_d = win_s[1];
                    if (win_s[1]) begin
                        cmd_d = '{we: r1_we, addr: r1_addr, wdata: r1_wdata};
                    end else begin
                        cmd_d = '{we: r0_we, addr: r0_addr, wdata: r0_wdata};
                    end
                    busy_d   = 1'b1;
                    rf_wen_d = cmd_d.we;
                    rf_ren_d = ~cmd_d.we;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                // gnt_q still identifies the owner of this access
                if (rf_ren_q) begin
                    rd_data_d = rf_data_out;
                    rvalid_d  = gnt_q;
                end else begin
                    rvalid_d  = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cmd_q      <= '0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_ren_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cmd_q      <= cmd_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_ren_q   <= rf_ren_d;
        end
    end

    assign r0_gnt     = gnt_q[0];
    assign r1_gnt     = gnt_q[1];
    assign r0_rvalid  = rvalid_q[0];
    assign r1_rvalid  = rvalid_q[1];
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign rf_wen     = rf_wen_q;
    assign rf_ren     = rf_ren_q;
    assign rf_addr    = cmd_q.addr;
    assign rf_data_in = cmd_q.wdata;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter: a transaction-level model predicts grants and read data.
module tb_rf_port_arbiter;
    import rf_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [1:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy, rf_wen, rf_ren;
    logic [31:0] rd_data, rf_data_in, rf_data_out;
    logic [1:0]  rf_addr;

    always #5 clk = ~clk;

    rf_port_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .rd_data(rd_data), .busy(busy), .rf_wen(rf_wen), .rf_ren(rf_ren),
        .rf_addr(rf_addr), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    // Register file stand-in: address 0 always reads 0
    logic [31:0] rf_mem [4];
    assign rf_data_out = (rf_addr == 2'd0) ? 32'h0 : rf_mem[rf_addr];
    always @(posedge clk) if (rf_wen) rf_mem[rf_addr] <= rf_data_in;

    typedef struct { int who; bit we; logic [1:0] addr; logic [31:0] wdata; int cyc; } gnt_exp_t;
    typedef struct { int who; logic [31:0] data; int cyc; } rd_exp_t;
    gnt_exp_t gq[$];
    rd_exp_t  rq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    bit          model_last = 1'b1;
    logic [31:0] ref_mem [4];
    bit          p_req [2];
    bit          p_we [2];
    logic [1:0]  p_addr [2];
    logic [31:0] p_wd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    gnt_exp_t ge;
    rd_exp_t  re;
    logic [1:0] mon_g, mon_v;
    always @(negedge clk) begin
        if (!rst) begin
            mon_g = {r1_gnt, r0_gnt};
            mon_v = {r1_rvalid, r0_rvalid};
            if (mon_g != 2'b00) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 32'(mon_g), 32'h0);
                end else begin
                    ge = gq.pop_front();
                    check("gnt_who", 32'(mon_g), 32'(2'b01 << ge.who));
                    check("gnt_cycle", cyc, ge.cyc);
                    check("busy_access", 32'(busy), 32'h1);
                    check("rf_wen", 32'(rf_wen), 32'(ge.we));
                    check("rf_ren", 32'(rf_ren), 32'(!ge.we));
                    check("rf_addr", 32'(rf_addr), 32'(ge.addr));
                    if (ge.we) check("rf_data_in", rf_data_in, ge.wdata);
                end
            end else begin
                check("idle_strobes", {29'h0, busy, rf_wen, rf_ren}, 32'h0);
            end
            if (mon_v != 2'b00) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'(mon_v), 32'h0);
                end else begin
                    re = rq.pop_front();
                    check("rvalid_who", 32'(mon_v), 32'(2'b01 << re.who));
                    check("rvalid_cycle", cyc, re.cyc);
                    check("rd_data", rd_data, re.data);
                end
            end
        end
    end

    task automatic drive_inputs();
        r0_req = p_req[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_wd[0];
        r1_req = p_req[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_wd[1];
    endtask

    task automatic set_cmd(input int i, input bit we, input logic [1:0] a, input logic [31:0] d);
        p_req[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wd[i] = d;
    endtask

    // One arbitration opportunity; abort asserts reset during the access cycle
    task automatic round(input bit abort = 1'b0);
        int w;
        drive_inputs();
        if (!p_req[0] && !p_req[1]) begin
            @(posedge clk); #1;
            return;
        end
`ifdef RF_ARB_FIXED_PRIO_EN
        w = p_req[0] ? 0 : 1;
`else
        if (p_req[0] && p_req[1]) w = model_last ? 0 : 1;
        else                      w = p_req[0] ? 0 : 1;
`endif
        gq.push_back('{who: w, we: p_we[w], addr: p_addr[w], wdata: p_wd[w], cyc: cyc + 1});
        if (p_we[w]) ref_mem[p_addr[w]] = p_wd[w];
        else if (!abort) rq.push_back('{who: w, data: (p_addr[w] == 2'd0) ? 32'h0 : ref_mem[p_addr[w]], cyc: cyc + 2});
        model_last = (w == 1);
        @(posedge clk);
        if (abort) begin
            @(negedge clk); #1;
            rst = 1'b1;
        end
        @(posedge clk); #1;
        p_req[w] = 1'b0;
        if (abort) begin
            rst = 1'b0;
            model_last = 1'b1;
            check("abort_busy", 32'(busy), 32'h0);
            check("abort_strobes", {30'h0, rf_wen, rf_ren}, 32'h0);
            check("abort_rvalid", {30'h0, r1_rvalid, r0_rvalid}, 32'h0);
            check("abort_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h0);
        end
        drive_inputs();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin rf_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        for (int i = 0; i < 2; i++) begin p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = 2'd0; p_wd[i] = 32'h0; end
        rst = 1'b1;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_outputs", {26'h0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rf_wen, rf_ren}, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rf_addr", 32'(rf_addr), 32'h0);
        check("rst_rf_data_in", rf_data_in, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_no_gnt", {28'h0, r0_gnt, r1_gnt, rf_wen, rf_ren}, 32'h0);
        end

        // First tie after reset, then a second tie
        set_cmd(0, 1'b1, 2'd1, 32'hA5A5_0001);
        set_cmd(1, 1'b1, 2'd3, 32'h5A5A_0003);
        round();
        set_cmd(0, 1'b1, 2'd1, 32'hA5A5_0011);
        round();
        round();

        set_cmd(0, 1'b1, 2'd2, 32'hDEAD_BEEF); round();
        set_cmd(0, 1'b0, 2'd2, 32'h0);         round();
        set_cmd(1, 1'b1, 2'd0, 32'h0000_1234); round();
        set_cmd(1, 1'b0, 2'd0, 32'h0);         round();

        // Both continuously requesting
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 2; i++)
                if (!p_req[i]) set_cmd(i, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)), $urandom);
            round();
        end
        while (p_req[0] || p_req[1]) round();

        // Reset during a read access, then a fresh read
        set_cmd(0, 1'b0, 2'd2, 32'h0); round(1'b1);
        set_cmd(0, 1'b0, 2'd2, 32'h0); round();

        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < 2; i++)
                if (!p_req[i] && $urandom_range(0, 2) != 0)
                    set_cmd(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            round();
        end
        while (p_req[0] || p_req[1]) round();

        repeat (4) @(posedge clk);
        #1;
        check("gnt_queue_drained", gq.size(), 32'h0);
        check("rd_queue_drained", rq.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
